// File: rtl/alu_muldiv_unit.sv
// Handshaked MIPS ALU with registered result, HI/LO, and iterative
// shift-add multiply / restoring divide (one step per clock).
module alu_muldiv_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       opcode,
  input  logic [5:0]       func_field,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             ovf,
  output logic             div0,
  output logic             illegal
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_hi, r_lo, r_result;
  logic               r_out_valid, r_zero, r_ovf, r_div0, r_illegal;
  logic [WIDTH-1:0]   r_pa, r_pb, r_opb;
  logic               r_neg_p, r_neg_r, r_ovf_pend;

  logic [WIDTH-1:0]   w_sum, w_dif, w_res, w_abs_a, w_abs_b;
  logic               w_add_ovf, w_sub_ovf, w_slt, w_sltu;
  logic               w_ovf, w_ill, w_mul, w_div, w_sgn, w_accept;
  logic [WIDTH:0]     w_madd, w_shift, w_trial;
  logic [2*WIDTH-1:0] w_prod, w_prod_fix;
  logic [WIDTH-1:0]   w_quo_fix, w_rem_fix;

  assign w_sum     = A + B;
  assign w_dif     = A - B;
  assign w_add_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (w_sum[WIDTH-1] != A[WIDTH-1]);
  assign w_sub_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (w_dif[WIDTH-1] != A[WIDTH-1]);
  assign w_slt     = $signed(A) < $signed(B);
  assign w_sltu    = A < B;

  always_comb begin
    w_res = '0;
    w_ovf = 1'b0;
    w_ill = 1'b0;
    w_mul = 1'b0;
    w_div = 1'b0;
    w_sgn = 1'b0;
    if (opcode == 6'h00) begin
      case (func_field)
        6'h20: begin w_res = w_sum; w_ovf = w_add_ovf; end
        6'h21: w_res = w_sum;
        6'h22: begin w_res = w_dif; w_ovf = w_sub_ovf; end
        6'h23: w_res = w_dif;
        6'h24: w_res = A & B;
        6'h25: w_res = A | B;
        6'h26: w_res = A ^ B;
        6'h27: w_res = ~(A | B);
        6'h2A: w_res = {{(WIDTH-1){1'b0}}, w_slt};
        6'h2B: w_res = {{(WIDTH-1){1'b0}}, w_sltu};
        6'h10: w_res = r_hi;
        6'h12: w_res = r_lo;
        6'h18: begin w_mul = 1'b1; w_sgn = 1'b1; end
        6'h19: w_mul = 1'b1;
        6'h1A: begin w_div = 1'b1; w_sgn = 1'b1; end
        6'h1B: w_div = 1'b1;
        default: w_ill = 1'b1;
      endcase
    end else begin
      case (opcode)
        6'h23, 6'h2B, 6'h08: begin w_res = w_sum; w_ovf = w_add_ovf; end
        6'h04, 6'h05:        begin w_res = w_dif; w_ovf = w_sub_ovf; end
        6'h09: w_res = w_sum;
        6'h0A: w_res = {{(WIDTH-1){1'b0}}, w_slt};
        6'h0B: w_res = {{(WIDTH-1){1'b0}}, w_sltu};
        6'h0C: w_res = A & B;
        6'h0D: w_res = A | B;
        default: w_ill = 1'b1;
      endcase
    end
  end

  assign in_ready = (r_state == S_IDLE) && (!r_out_valid || out_ready);
  assign w_accept = in_valid && in_ready;

  assign w_abs_a = (w_sgn && A[WIDTH-1]) ? (~A + 1'b1) : A;
  assign w_abs_b = (w_sgn && B[WIDTH-1]) ? (~B + 1'b1) : B;

  // Multiply: r_pa accumulates the high half, r_pb shifts out multiplier bits
  // and fills with product bits from the top.
  assign w_madd     = {1'b0, r_pa} + (r_pb[0] ? {1'b0, r_opb} : '0);
  assign w_prod     = {r_pa, r_pb};
  assign w_prod_fix = r_neg_p ? (~w_prod + 1'b1) : w_prod;

  // Divide: r_pa is the partial remainder, r_pb shifts dividend out / quotient in.
  assign w_shift   = {r_pa, r_pb[WIDTH-1]};
  assign w_trial   = w_shift - {1'b0, r_opb};
  assign w_quo_fix = r_neg_p ? (~r_pb + 1'b1) : r_pb;
  assign w_rem_fix = r_neg_r ? (~r_pa + 1'b1) : r_pa;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_result    <= '0;
      r_out_valid <= 1'b0;
      r_zero      <= 1'b0;
      r_ovf       <= 1'b0;
      r_div0      <= 1'b0;
      r_illegal   <= 1'b0;
      r_pa        <= '0;
      r_pb        <= '0;
      r_opb       <= '0;
      r_neg_p     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_ovf_pend  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_out_valid && out_ready) r_out_valid <= 1'b0;
          if (w_accept) begin
            if (w_mul || (w_div && B != '0)) begin
              r_state    <= w_mul ? S_MUL : S_DIV;
              r_cnt      <= '0;
              r_pa       <= '0;
              r_pb       <= w_abs_a;
              r_opb      <= w_abs_b;
              r_neg_p    <= w_sgn && (A[WIDTH-1] ^ B[WIDTH-1]);
              r_neg_r    <= w_sgn && A[WIDTH-1];
              r_ovf_pend <= w_div && w_sgn && (A == MIN_VAL) && (B == '1);
            end else if (w_div) begin
              r_hi        <= A;
              r_lo        <= '1;
              r_result    <= '1;
              r_zero      <= 1'b0;
              r_ovf       <= 1'b0;
              r_div0      <= 1'b1;
              r_illegal   <= 1'b0;
              r_out_valid <= 1'b1;
            end else begin
              r_result    <= w_res;
              r_zero      <= (w_res == '0);
              r_ovf       <= w_ovf;
              r_div0      <= 1'b0;
              r_illegal   <= w_ill;
              r_out_valid <= 1'b1;
            end
          end
        end
        S_MUL: begin
          if (r_cnt == CNT_W'(WIDTH)) begin
            r_hi        <= w_prod_fix[2*WIDTH-1:WIDTH];
            r_lo        <= w_prod_fix[WIDTH-1:0];
            r_result    <= w_prod_fix[WIDTH-1:0];
            r_zero      <= (w_prod_fix == '0);
            r_ovf       <= 1'b0;
            r_div0      <= 1'b0;
            r_illegal   <= 1'b0;
            r_out_valid <= 1'b1;
            r_state     <= S_IDLE;
          end else begin
            {r_pa, r_pb} <= {w_madd, r_pb[WIDTH-1:1]};
            r_cnt        <= r_cnt + CNT_W'(1);
          end
        end
        S_DIV: begin
          if (r_cnt == CNT_W'(WIDTH)) begin
            r_hi        <= w_rem_fix;
            r_lo        <= w_quo_fix;
            r_result    <= w_quo_fix;
            r_zero      <= (w_rem_fix == '0) && (w_quo_fix == '0);
            r_ovf       <= r_ovf_pend;
            r_div0      <= 1'b0;
            r_illegal   <= 1'b0;
            r_out_valid <= 1'b1;
            r_state     <= S_IDLE;
          end else begin
            r_pa  <= w_trial[WIDTH] ? w_shift[WIDTH-1:0] : w_trial[WIDTH-1:0];
            r_pb  <= {r_pb[WIDTH-2:0], ~w_trial[WIDTH]};
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign zero      = r_zero;
  assign ovf       = r_ovf;
  assign div0      = r_div0;
  assign illegal   = r_illegal;

endmodule

// File: tb/tb_alu_muldiv_unit.sv
// Directed bench for alu_muldiv_unit: vector table for single-cycle ops,
// hand sequences for mult/div latency, backpressure and mid-op reset.
module tb_alu_muldiv_unit;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst_n, in_valid, out_ready;
  logic [5:0]    opcode, func_field;
  logic [W-1:0]  A, B;
  logic          in_ready, out_valid, zero, ovf, div0, illegal;
  logic [W-1:0]  result;

  int n_checks = 0;
  int n_pass   = 0;

  alu_muldiv_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .func_field(func_field), .A(A), .B(B),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .zero(zero), .ovf(ovf), .div0(div0), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        z;
    logic        o;
    logic        ill;
  } vec_t;

  vec_t vecs[18];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic start_op(input logic [5:0] op, input logic [5:0] fn,
                          input logic [31:0] a, input logic [31:0] b);
    int g = 0;
    while (!in_ready && g < 50) begin
      @(posedge clk); #1;
      g++;
    end
    check("in_ready_before_issue", 64'(in_ready), 64'd1);
    opcode = op; func_field = fn; A = a; B = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic single(input string nm, input logic [5:0] op, input logic [5:0] fn,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    start_op(op, fn, a, b);
    check({nm, "_valid"}, 64'(out_valid), 64'd1);
    check({nm, "_result"}, 64'(result), 64'(exp));
  endtask

  // extra_edges: clock edges after the accept edge until out_valid rises
  task automatic run_multi(input string nm, input logic [5:0] fn,
                           input logic [31:0] a, input logic [31:0] b,
                           input int extra_edges, input logic [31:0] exp_lo,
                           input logic exp_ovf, input logic exp_div0);
    int lat = 0;
    logic busy_ok = 1'b1;
    start_op(6'h00, fn, a, b);
    while (!out_valid && lat < 60) begin
      if (in_ready) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    check({nm, "_latency"}, 64'(lat), 64'(extra_edges));
    check({nm, "_busy"}, 64'(busy_ok), 64'd1);
    check({nm, "_lo"}, 64'(result), 64'(exp_lo));
    check({nm, "_flags"}, {62'd0, ovf, div0}, {62'd0, exp_ovf, exp_div0});
  endtask

  initial begin
    vecs[0]  = '{6'h00, 6'h20, 32'h0000_2222, 32'h0000_1111, 32'h0000_3333, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{6'h00, 6'h24, 32'h0000_2222, 32'h0000_1111, 32'h0000_0000, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{6'h23, 6'h00, 32'h0000_2222, 32'h0000_1111, 32'h0000_3333, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{6'h04, 6'h00, 32'h0000_5555, 32'h0000_5555, 32'h0000_0000, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{6'h00, 6'h2A, 32'h0000_1111, 32'h0000_2222, 32'h0000_0001, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{6'h00, 6'h2B, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{6'h00, 6'h2A, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{6'h00, 6'h20, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{6'h00, 6'h21, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{6'h00, 6'h22, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{6'h00, 6'h23, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{6'h00, 6'h26, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{6'h00, 6'h27, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{6'h0D, 6'h00, 32'h0000_1200, 32'h0000_0034, 32'h0000_1234, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{6'h08, 6'h00, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
    vecs[15] = '{6'h05, 6'h00, 32'h0000_0010, 32'h0000_0003, 32'h0000_000D, 1'b0, 1'b0, 1'b0};
    vecs[16] = '{6'h00, 6'h3F, 32'h1234_5678, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    vecs[17] = '{6'h3F, 6'h00, 32'h1234_5678, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 1'b1};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    opcode = '0; func_field = '0; A = '0; B = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_result", 64'(result), 64'd0);
    check("reset_flags", {60'd0, zero, ovf, div0, illegal}, 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("reset_in_ready", 64'(in_ready), 64'd1);

    // single-cycle ops issued back-to-back, one per clock
    for (int i = 0; i < 18; i++) begin
      opcode = vecs[i].op; func_field = vecs[i].fn; A = vecs[i].a; B = vecs[i].b;
      in_valid = 1'b1;
      check($sformatf("vec%0d_in_ready", i), 64'(in_ready), 64'd1);
      @(posedge clk); #1;
      check($sformatf("vec%0d_valid", i), 64'(out_valid), 64'd1);
      check($sformatf("vec%0d_out", i),
            {29'd0, result, zero, ovf, illegal, div0},
            {29'd0, vecs[i].res, vecs[i].z, vecs[i].o, vecs[i].ill, 1'b0});
    end
    in_valid = 1'b0;

    run_multi("mult_neg", 6'h18, 32'hFFFF_FFFE, 32'h0000_0003, 33, 32'hFFFF_FFFA, 1'b0, 1'b0);
    single("mfhi_mult", 6'h00, 6'h10, '0, '0, 32'hFFFF_FFFF);
    single("mflo_mult", 6'h00, 6'h12, '0, '0, 32'hFFFF_FFFA);
    run_multi("div_neg", 6'h1A, 32'hFFFF_FFF9, 32'h0000_0002, 33, 32'hFFFF_FFFD, 1'b0, 1'b0);
    single("mfhi_div", 6'h00, 6'h10, '0, '0, 32'hFFFF_FFFF);
    run_multi("div_negdiv", 6'h1A, 32'h0000_0007, 32'hFFFF_FFFE, 33, 32'hFFFF_FFFD, 1'b0, 1'b0);
    single("mfhi_div2", 6'h00, 6'h10, '0, '0, 32'h0000_0001);
    run_multi("divu_by0", 6'h1B, 32'h1234_5678, 32'h0000_0000, 0, 32'hFFFF_FFFF, 1'b0, 1'b1);
    single("mfhi_div0", 6'h00, 6'h10, '0, '0, 32'h1234_5678);
    run_multi("div_min", 6'h1A, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h8000_0000, 1'b1, 1'b0);
    single("mfhi_min", 6'h00, 6'h10, '0, '0, 32'h0000_0000);
    run_multi("divu", 6'h1B, 32'h0000_0064, 32'h0000_0007, 33, 32'h0000_000E, 1'b0, 1'b0);
    single("mfhi_divu", 6'h00, 6'h10, '0, '0, 32'h0000_0002);
    run_multi("multu_max", 6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 32'h0000_0001, 1'b0, 1'b0);
    single("mfhi_multu", 6'h00, 6'h10, '0, '0, 32'hFFFF_FFFE);

    // backpressure: result held, no new accept until consumer takes it
    @(posedge clk); #1;
    out_ready = 1'b0;
    start_op(6'h00, 6'h21, 32'd1, 32'd2);
    check("bp_first", {31'd0, out_valid, result}, {31'd0, 1'b1, 32'd3});
    opcode = 6'h00; func_field = 6'h23; A = 32'd9; B = 32'd4; in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      check($sformatf("bp_in_ready_%0d", c), 64'(in_ready), 64'd0);
      @(posedge clk); #1;
      check($sformatf("bp_hold_%0d", c), {31'd0, out_valid, result}, {31'd0, 1'b1, 32'd3});
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_back_to_back", {31'd0, out_valid, result}, {31'd0, 1'b1, 32'd5});
    @(posedge clk); #1;
    check("bp_drain", 64'(out_valid), 64'd0);

    // reset mid-multiply discards partial work and clears HI/LO
    start_op(6'h00, 6'h18, 32'd5, 32'd7);
    repeat (9) @(posedge clk);
    #1;
    check("midreset_busy", 64'(in_ready), 64'd0);
    rst_n = 1'b0;
    #2;
    check("midreset_out_valid", 64'(out_valid), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("midreset_in_ready", 64'(in_ready), 64'd1);
    check("midreset_still_idle", 64'(out_valid), 64'd0);
    single("midreset_hi", 6'h00, 6'h10, '0, '0, 32'h0000_0000);
    single("midreset_lo", 6'h00, 6'h12, '0, '0, 32'h0000_0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
